issue_queue: RTL and testbench

Oldest-first issue queue for the out-of-order backend, sitting directly upstream of the register-read stage. It accepts one renamed micro-op per cycle from dispatch and holds it until both physical source operands are ready. Ready state comes from operand-ready flags at dispatch and from destination-tag wakeups broadcast on the four execute bypass ports. Each cycle it selects the oldest ready entry into a registered output slot that feeds register read (src1/src2 physical indices plus payload) under a valid/ready handshake.

---
 rtl/issue_queue.sv | 194 +++++++++++++++++++
 tb/tb_issue_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Oldest-first collapsing issue queue: holds renamed uops until both sources are
// ready, then selects the oldest eligible entry into a registered output slot.
module issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 32,
    parameter int NUM_WAKE  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [PREG_W-1:0]            disp_src1_index,
    input  logic [PREG_W-1:0]            disp_src2_index,
    input  logic                         disp_src1_rdy,
    input  logic                         disp_src2_rdy,
    input  logic [PREG_W-1:0]            disp_dst_index,
    input  logic [PAYLOAD_W-1:0]         disp_payload,
    input  logic [NUM_WAKE-1:0]          wake_valid,
    input  logic [NUM_WAKE*PREG_W-1:0]   wake_tag,
    output logic                         sel_valid,
    input  logic                         sel_ready,
    output logic [PREG_W-1:0]            sel_src1_index,
    output logic [PREG_W-1:0]            sel_src2_index,
    output logic [PREG_W-1:0]            sel_dst_index,
    output logic [PAYLOAD_W-1:0]         sel_payload,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);

    function automatic logic wake_hit(input logic [PREG_W-1:0]          idx,
                                      input logic [NUM_WAKE-1:0]        wv,
                                      input logic [NUM_WAKE*PREG_W-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < NUM_WAKE; l++) begin
            hit = hit | (wv[l] & (wt[l*PREG_W +: PREG_W] == idx));
        end
        return hit;
    endfunction

    logic [PREG_W-1:0]    src1_r [DEPTH];
    logic [PREG_W-1:0]    src2_r [DEPTH];
    logic [PREG_W-1:0]    dst_r  [DEPTH];
    logic [PAYLOAD_W-1:0] pay_r  [DEPTH];
    logic [DEPTH-1:0]     rdy1_r;
    logic [DEPTH-1:0]     rdy2_r;
    logic [CW-1:0]        count_r;

    logic                 sel_valid_r;
    logic [PREG_W-1:0]    sel_src1_r;
    logic [PREG_W-1:0]    sel_src2_r;
    logic [PREG_W-1:0]    sel_dst_r;
    logic [PAYLOAD_W-1:0] sel_pay_r;

    logic [DEPTH-1:0]     elig_s;
    logic                 any_elig_s;
    logic [CW-1:0]        take_idx_s;
    logic [PREG_W-1:0]    take_src1_s;
    logic [PREG_W-1:0]    take_src2_s;
    logic [PREG_W-1:0]    take_dst_s;
    logic [PAYLOAD_W-1:0] take_pay_s;
    logic                 slot_free_s;
    logic                 take_s;
    logic                 disp_fire_s;
    logic                 disp_rdy1_s;
    logic                 disp_rdy2_s;
    logic [CW-1:0]        wr_pos_s;
    logic [CW-1:0]        n_count_s;

    logic [PREG_W-1:0]    n_src1_s [DEPTH];
    logic [PREG_W-1:0]    n_src2_s [DEPTH];
    logic [PREG_W-1:0]    n_dst_s  [DEPTH];
    logic [PAYLOAD_W-1:0] n_pay_s  [DEPTH];
    logic [DEPTH-1:0]     n_rdy1_s;
    logic [DEPTH-1:0]     n_rdy2_s;

    assign disp_ready     = (count_r != CW'(DEPTH));
    assign count          = count_r;
    assign sel_valid      = sel_valid_r;
    assign sel_src1_index = sel_src1_r;
    assign sel_src2_index = sel_src2_r;
    assign sel_dst_index  = sel_dst_r;
    assign sel_payload    = sel_pay_r;

    // Oldest-eligible select; scanning downward leaves the lowest index winning.
    always_comb begin
        any_elig_s  = 1'b0;
        take_idx_s  = {CW{1'b0}};
        take_src1_s = {PREG_W{1'b0}};
        take_src2_s = {PREG_W{1'b0}};
        take_dst_s  = {PREG_W{1'b0}};
        take_pay_s  = {PAYLOAD_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            elig_s[i]   = rdy1_r[i] & rdy2_r[i] & (CW'(i) < count_r);
            take_idx_s  = elig_s[i] ? CW'(i)    : take_idx_s;
            take_src1_s = elig_s[i] ? src1_r[i] : take_src1_s;
            take_src2_s = elig_s[i] ? src2_r[i] : take_src2_s;
            take_dst_s  = elig_s[i] ? dst_r[i]  : take_dst_s;
            take_pay_s  = elig_s[i] ? pay_r[i]  : take_pay_s;
        end
        any_elig_s  = |elig_s;
        slot_free_s = ~sel_valid_r | sel_ready;
        take_s      = slot_free_s & any_elig_s;
        disp_fire_s = disp_valid & disp_ready;
        wr_pos_s    = count_r - CW'(take_s);
        n_count_s   = count_r + CW'(disp_fire_s) - CW'(take_s);
        disp_rdy1_s = disp_src1_rdy | (disp_src1_index == {PREG_W{1'b0}})
                    | wake_hit(disp_src1_index, wake_valid, wake_tag);
        disp_rdy2_s = disp_src2_rdy | (disp_src2_index == {PREG_W{1'b0}})
                    | wake_hit(disp_src2_index, wake_valid, wake_tag);
    end

    // Next entry contents: collapse over the taken entry, apply wakeups, then append dispatch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            n_src1_s[i] = src1_r[i];
            n_src2_s[i] = src2_r[i];
            n_dst_s[i]  = dst_r[i];
            n_pay_s[i]  = pay_r[i];
            n_rdy1_s[i] = rdy1_r[i];
            n_rdy2_s[i] = rdy2_r[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (take_s && (CW'(i) >= take_idx_s)) begin
                n_src1_s[i] = src1_r[i+1];
                n_src2_s[i] = src2_r[i+1];
                n_dst_s[i]  = dst_r[i+1];
                n_pay_s[i]  = pay_r[i+1];
                n_rdy1_s[i] = rdy1_r[i+1];
                n_rdy2_s[i] = rdy2_r[i+1];
            end else begin
                n_src1_s[i] = n_src1_s[i];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_rdy1_s[i] = n_rdy1_s[i] | wake_hit(n_src1_s[i], wake_valid, wake_tag);
            n_rdy2_s[i] = n_rdy2_s[i] | wake_hit(n_src2_s[i], wake_valid, wake_tag);
            if (disp_fire_s && (CW'(i) == wr_pos_s)) begin
                n_src1_s[i] = disp_src1_index;
                n_src2_s[i] = disp_src2_index;
                n_dst_s[i]  = disp_dst_index;
                n_pay_s[i]  = disp_payload;
                n_rdy1_s[i] = disp_rdy1_s;
                n_rdy2_s[i] = disp_rdy2_s;
            end else begin
                n_dst_s[i]  = n_dst_s[i];
            end
        end
    end

    // State update: reset, then flush, then normal queue/slot advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= {CW{1'b0}};
            sel_valid_r <= 1'b0;
            sel_src1_r  <= {PREG_W{1'b0}};
            sel_src2_r  <= {PREG_W{1'b0}};
            sel_dst_r   <= {PREG_W{1'b0}};
            sel_pay_r   <= {PAYLOAD_W{1'b0}};
            rdy1_r      <= {DEPTH{1'b0}};
            rdy2_r      <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                src1_r[i] <= {PREG_W{1'b0}};
                src2_r[i] <= {PREG_W{1'b0}};
                dst_r[i]  <= {PREG_W{1'b0}};
                pay_r[i]  <= {PAYLOAD_W{1'b0}};
            end
        end else if (flush) begin
            count_r     <= {CW{1'b0}};
            sel_valid_r <= 1'b0;
        end else begin
            count_r <= n_count_s;
            rdy1_r  <= n_rdy1_s;
            rdy2_r  <= n_rdy2_s;
            for (int i = 0; i < DEPTH; i++) begin
                src1_r[i] <= n_src1_s[i];
                src2_r[i] <= n_src2_s[i];
                dst_r[i]  <= n_dst_s[i];
                pay_r[i]  <= n_pay_s[i];
            end
            if (slot_free_s) begin
                sel_valid_r <= any_elig_s;
                if (any_elig_s) begin
                    sel_src1_r <= take_src1_s;
                    sel_src2_r <= take_src2_s;
                    sel_dst_r  <= take_dst_s;
                    sel_pay_r  <= take_pay_s;
                end
            end
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the oldest-first issue rules.
module tb_issue_queue;
    localparam int DEPTH = 8, PREG_W = 6, PAYLOAD_W = 32, NUM_WAKE = 4;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst, flush, disp_valid, disp_ready, disp_src1_rdy, disp_src2_rdy;
    logic [PREG_W-1:0] disp_src1_index, disp_src2_index, disp_dst_index;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic [NUM_WAKE-1:0] wake_valid;
    logic [NUM_WAKE*PREG_W-1:0] wake_tag;
    logic [PREG_W-1:0] wtag [NUM_WAKE];
    logic sel_valid, sel_ready;
    logic [PREG_W-1:0] sel_src1_index, sel_src2_index, sel_dst_index;
    logic [PAYLOAD_W-1:0] sel_payload;
    logic [CW-1:0] count;

    issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W), .NUM_WAKE(NUM_WAKE)) dut (
        .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1_index(disp_src1_index), .disp_src2_index(disp_src2_index),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_dst_index(disp_dst_index), .disp_payload(disp_payload),
        .wake_valid(wake_valid), .wake_tag(wake_tag),
        .sel_valid(sel_valid), .sel_ready(sel_ready),
        .sel_src1_index(sel_src1_index), .sel_src2_index(sel_src2_index),
        .sel_dst_index(sel_dst_index), .sel_payload(sel_payload), .count(count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int l = 0; l < NUM_WAKE; l++) wake_tag[l*PREG_W +: PREG_W] = wtag[l];
    end

    typedef struct {
        logic [PREG_W-1:0]    s1, s2, dst;
        logic                 r1, r2;
        logic [PAYLOAD_W-1:0] pay;
    } uop_t;

    uop_t mq[$];
    logic m_sv;
    logic [PREG_W-1:0] m_s1, m_s2, m_dst;
    logic [PAYLOAD_W-1:0] m_pay;
    int err_cnt = 0, chk_cnt = 0;
    logic [PAYLOAD_W-1:0] got_q[$];
    logic [PAYLOAD_W-1:0] held_pay;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_hit(input logic [PREG_W-1:0] t);
        for (int l = 0; l < NUM_WAKE; l++) if (wake_valid[l] && wtag[l] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: remove oldest ready uop into the slot, wake the rest, append the new one.
    task automatic model_step();
        int idx;
        uop_t u;
        logic fire, free;
        if (rst) begin
            mq.delete(); m_sv = 1'b0;
            m_s1 = '0; m_s2 = '0; m_dst = '0; m_pay = '0;
        end else if (flush) begin
            mq.delete(); m_sv = 1'b0;
        end else begin
            fire = disp_valid && (mq.size() != DEPTH);
            free = !m_sv || sel_ready;
            if (free) begin
                idx = -1;
                for (int i = 0; i < mq.size(); i++) if (idx < 0 && mq[i].r1 && mq[i].r2) idx = i;
                if (idx >= 0) begin
                    m_sv = 1'b1; m_s1 = mq[idx].s1; m_s2 = mq[idx].s2;
                    m_dst = mq[idx].dst; m_pay = mq[idx].pay;
                    mq.delete(idx);
                end else begin
                    m_sv = 1'b0;
                end
            end
            for (int i = 0; i < mq.size(); i++) begin
                u = mq[i];
                u.r1 = u.r1 | m_hit(u.s1);
                u.r2 = u.r2 | m_hit(u.s2);
                mq[i] = u;
            end
            if (fire) begin
                u.s1 = disp_src1_index; u.s2 = disp_src2_index;
                u.dst = disp_dst_index; u.pay = disp_payload;
                u.r1 = disp_src1_rdy || (disp_src1_index == 0) || m_hit(disp_src1_index);
                u.r2 = disp_src2_rdy || (disp_src2_index == 0) || m_hit(disp_src2_index);
                mq.push_back(u);
            end
        end
    endtask

    task automatic compare_all();
        check_val("count", 64'(count), 64'(mq.size()));
        check_val("disp_ready", 64'(disp_ready), 64'(mq.size() != DEPTH));
        check_val("sel_valid", 64'(sel_valid), 64'(m_sv));
        if (m_sv) begin
            check_val("sel_src1", 64'(sel_src1_index), 64'(m_s1));
            check_val("sel_src2", 64'(sel_src2_index), 64'(m_s2));
            check_val("sel_dst", 64'(sel_dst_index), 64'(m_dst));
            check_val("sel_payload", 64'(sel_payload), 64'(m_pay));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        rst = 1'b0; flush = 1'b0; disp_valid = 1'b0;
        disp_src1_index = '0; disp_src2_index = '0; disp_dst_index = '0;
        disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_payload = '0;
        wake_valid = '0;
        for (int l = 0; l < NUM_WAKE; l++) wtag[l] = '0;
    endtask

    task automatic drive_disp(input logic [PREG_W-1:0] s1, input logic r1,
                              input logic [PREG_W-1:0] s2, input logic r2,
                              input logic [PAYLOAD_W-1:0] pay);
        disp_valid = 1'b1;
        disp_src1_index = s1; disp_src1_rdy = r1;
        disp_src2_index = s2; disp_src2_rdy = r2;
        disp_dst_index = pay[PREG_W-1:0]; disp_payload = pay;
    endtask

    task automatic do_flush();
        clear_inputs();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        clear_inputs();
        sel_ready = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_sel_valid", 64'(sel_valid), 64'd0);
        check_val("rst_disp_ready", 64'(disp_ready), 64'd1);
        check_val("rst_sel_payload", 64'(sel_payload), 64'd0);
        check_val("rst_sel_src1", 64'(sel_src1_index), 64'd0);

        // Minimum latency with x0 as src2
        drive_disp(6'd5, 1'b1, 6'd0, 1'b0, 32'h100);
        cycle();
        check_val("t1_count1", 64'(count), 64'd1);
        clear_inputs();
        cycle();
        check_val("t1_sel_valid", 64'(sel_valid), 64'd1);
        check_val("t1_src1", 64'(sel_src1_index), 64'd5);
        check_val("t1_src2", 64'(sel_src2_index), 64'd0);
        check_val("t1_count0", 64'(count), 64'd0);
        cycle();

        // Younger ready uop bypasses older waiting one; wakeup releases the older
        drive_disp(6'd7, 1'b0, 6'd0, 1'b0, 32'hA);
        cycle();
        drive_disp(6'd3, 1'b1, 6'd4, 1'b1, 32'hB);
        cycle();
        clear_inputs();
        cycle();
        check_val("t2_b_first", 64'(sel_payload), 64'hB);
        wake_valid = 4'b0100; wtag[2] = 6'd7;
        cycle();
        check_val("t2_idle", 64'(sel_valid), 64'd0);
        clear_inputs();
        cycle();
        check_val("t2_a_valid", 64'(sel_valid), 64'd1);
        check_val("t2_a_payload", 64'(sel_payload), 64'hA);
        cycle();

        // Same-cycle wakeup at dispatch is captured
        drive_disp(6'd11, 1'b1, 6'd9, 1'b0, 32'hC);
        wake_valid = 4'b0001; wtag[0] = 6'd9;
        cycle();
        clear_inputs();
        cycle();
        check_val("t3_valid", 64'(sel_valid), 64'd1);
        check_val("t3_payload", 64'(sel_payload), 64'hC);
        cycle();

        // Fill, overflow attempt, then wake all and drain in age order
        for (int i = 0; i < DEPTH; i++) begin
            drive_disp(6'(20 + i), 1'b0, 6'd0, 1'b0, 32'h400 + i);
            cycle();
        end
        check_val("t4_full_ready", 64'(disp_ready), 64'd0);
        drive_disp(6'd1, 1'b1, 6'd0, 1'b1, 32'h4FF);
        cycle();
        check_val("t4_full_count", 64'(count), 64'd8);
        clear_inputs();
        wake_valid = 4'hF;
        for (int l = 0; l < NUM_WAKE; l++) wtag[l] = 6'(20 + l);
        cycle();
        for (int l = 0; l < NUM_WAKE; l++) wtag[l] = 6'(24 + l);
        got_q.delete();
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (c == 0) clear_inputs();
            if (sel_valid) got_q.push_back(sel_payload);
        end
        check_val("t4_issue_cnt", 64'(got_q.size()), 64'd8);
        for (int k = 0; k < got_q.size(); k++) check_val("t4_order", 64'(got_q[k]), 64'(32'h400 + k));

        // Backpressure holds the slot and the queue
        do_flush();
        sel_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_disp(6'd2, 1'b1, 6'd3, 1'b1, 32'h500 + i);
            cycle();
        end
        clear_inputs();
        held_pay = sel_payload;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check_val("t5_stable", 64'(sel_payload), 64'h500);
            check_val("t5_count", 64'(count), 64'd2);
        end
        sel_ready = 1'b1;
        cycle();
        check_val("t5_release", 64'(sel_payload), 64'h501);

        // Flush with a loaded queue and slot drops everything, incl. same-cycle dispatch
        do_flush();
        sel_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_disp(6'd2, 1'b1, 6'd3, 1'b1, 32'h600 + i);
            cycle();
        end
        check_val("t6_count5", 64'(count), 64'd5);
        check_val("t6_slot", 64'(sel_valid), 64'd1);
        flush = 1'b1;
        drive_disp(6'd2, 1'b1, 6'd3, 1'b1, 32'h6FF);
        cycle();
        check_val("t6_flush_count", 64'(count), 64'd0);
        check_val("t6_flush_valid", 64'(sel_valid), 64'd0);
        clear_inputs();
        sel_ready = 1'b1;
        cycle();
        check_val("t6_no_retain", 64'(count), 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            disp_valid = ($urandom % 10) < 7;
            disp_src1_index = 6'($urandom_range(0, 15));
            disp_src2_index = 6'($urandom_range(0, 15));
            disp_src1_rdy = ($urandom % 4) == 0;
            disp_src2_rdy = ($urandom % 4) == 0;
            disp_dst_index = 6'($urandom_range(0, 63));
            disp_payload = 32'h10000 + n;
            for (int l = 0; l < NUM_WAKE; l++) begin
                wake_valid[l] = ($urandom % 3) == 0;
                wtag[l] = 6'($urandom_range(0, 15));
            end
            sel_ready = ($urandom % 4) != 0;
            flush = ($urandom % 64) == 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
